// File: rtl/aud_pkg.sv
// Shared types and constants for the audio record path.
// Holds the FSM state enum, sample/address widths and the default end address.
package aud_pkg;

  localparam int SAMPLE_W = 16;
  localparam int ADDR_W   = 20;
  localparam int CNT_W    = 4;

  localparam logic [ADDR_W-1:0] ADDR_MAX_DEF = 20'hFFFFF;
  localparam logic [CNT_W-1:0]  BIT_LAST     = CNT_W'(SAMPLE_W - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_SHIFT = 3'd2,
    S_WRITE = 3'd3,
    S_PAUSE = 3'd4
  } aud_state_e;

endpackage

// File: rtl/aud_edge_det.sv
// Registered edge detector with a sample enable.
// Ports: i_clk, i_rst (async high), i_sig, i_en (sample strobe), o_edge.
// FALL=0 reports a rise, FALL=1 a fall, measured against the value
// held at the previous enabled sample.
module aud_edge_det #(
  parameter bit FALL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sig,
  input  logic i_en,
  output logic o_edge
);

  logic prev_q, prev_d;

  always_comb begin
    prev_d = prev_q;
    if (i_en) prev_d = i_sig;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) prev_q <= 1'b0;
    else       prev_q <= prev_d;
  end

  assign o_edge = FALL ? (i_en & prev_q & ~i_sig)
                       : (i_en & ~prev_q & i_sig);

endmodule

// File: rtl/aud_record.sv
// I2S left-channel recorder writing 16-bit samples to SRAM.
// Ports: i_clk, i_rst, i_start/i_pause/i_stop commands, codec i_bclk,
// i_adclrck, i_adcdat; SRAM o_sram_we/addr/data; o_stop_addr; o_state.
module aud_record
  import aud_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ADDR_MAX = ADDR_MAX_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic                i_pause,
  input  logic                i_stop,
  input  logic                i_bclk,
  input  logic                i_adclrck,
  input  logic                i_adcdat,
  output logic                o_sram_we,
  output logic [ADDR_W-1:0]   o_sram_addr,
  output logic [SAMPLE_W-1:0] o_sram_data,
  output logic [ADDR_W-1:0]   o_stop_addr,
  output logic [2:0]          o_state
);

  aud_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   stop_q, stop_d;
  logic [SAMPLE_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]    bit_q, bit_d;
  logic                bclk_rise;
  logic                frame_start;

  aud_edge_det u_bclk (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_sig  (i_bclk),
    .i_en   (1'b1),
    .o_edge (bclk_rise)
  );

  // lrc is only sampled on bclk rises, so a fall here is the
  // left-frame delay bit: lrc=0 now, lrc=1 at the previous rise.
  aud_edge_det #(.FALL(1'b1)) u_lrc (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_sig  (i_adclrck),
    .i_en   (bclk_rise),
    .o_edge (frame_start)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_WAIT;
          addr_d  = '0;
          bit_d   = '0;
        end
      end
      S_WAIT: begin
        if (i_stop)           state_d = S_IDLE;
        else if (i_pause)     state_d = S_PAUSE;
        else if (frame_start) begin
          state_d = S_SHIFT;
          bit_d   = '0;
        end
      end
      S_SHIFT: begin
        if (i_stop)         state_d = S_IDLE;
        else if (i_pause)   state_d = S_PAUSE;
        else if (bclk_rise) begin
          shift_d = {shift_q[SAMPLE_W-2:0], i_adcdat};
          bit_d   = bit_q + CNT_W'(1);
          if (bit_q == BIT_LAST) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        // The strobe is issued regardless of commands; they only
        // steer where we go afterwards.
        stop_d = addr_q;
        if (addr_q != ADDR_MAX) addr_d = addr_q + ADDR_W'(1);
        if (i_stop)                  state_d = S_IDLE;
        else if (i_pause)            state_d = S_PAUSE;
        else if (addr_q == ADDR_MAX) state_d = S_IDLE;
        else                         state_d = S_WAIT;
      end
      S_PAUSE: begin
        if (i_stop)       state_d = S_IDLE;
        else if (i_pause) state_d = S_PAUSE;
        else if (i_start) state_d = S_WAIT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      stop_q  <= '0;
      shift_q <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
    end
  end

  assign o_sram_we   = (state_q == S_WRITE);
  assign o_sram_addr = addr_q;
  assign o_sram_data = shift_q;
  assign o_stop_addr = stop_q;
  assign o_state     = state_q;

endmodule

// File: doc/aud_record.md
AUD_RECORD -- requirements
Module: aud_record

Interface
REQ-001 Parameter ADDR_MAX, default 20'hFFFFF: highest SRAM word address the block writes; reaching it ends recording.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-003 i_clk  in  1  system clock; all logic on its rising edge.
REQ-004 i_rst  in  1  asynchronous active-high reset.
REQ-005 i_start  in  1  level; begin (IDLE) or resume (PAUSE) recording.
REQ-006 i_pause  in  1  level; suspend recording.
REQ-007 i_stop  in  1  level; end recording.
REQ-008 i_bclk  in  1  codec bit clock, oversampled by i_clk (at least 4x).
REQ-009 i_adclrck  in  1  codec ADC LR clock; 0 = left channel.
REQ-010 i_adcdat  in  1  codec serial ADC data, MSB first, I2S format.
REQ-011 o_sram_we  out  1  one-cycle write strobe.
REQ-012 o_sram_addr  out  20  write address; valid while o_sram_we is 1.
REQ-013 o_sram_data  out  16  captured left-channel sample; valid while o_sram_we is 1.
REQ-014 o_stop_addr  out  20  address of the last written sample; this is the playback end address.
REQ-015 o_state  out  3  current FSM state encoding.

Function
REQ-016 Edge detection SHALL use registered copies of i_bclk and i_adclrck; a rise is i_bclk=1 with previous=0; all serial sampling occurs only on bclk rises.
REQ-017 FSM states: S_IDLE=0, S_WAIT=1, S_SHIFT=2, S_WRITE=3, S_PAUSE=4.
REQ-018 Command priority, evaluated every cycle in the non-idle states: i_stop > i_pause > i_start.
REQ-019 IDLE: on i_start, go to WAIT, clear the address counter to 0, and clear the bit counter.
REQ-020 WAIT: at a bclk rise where sampled lrc=0 and the previous sampled lrc=1 (I2S delay bit), go to SHIFT; the data bit is ignored.
REQ-021 SHIFT: on each of the next 16 bclk rises, shift i_adcdat into bit 0 of the shift register; after the 16th rise, go to WRITE.
REQ-022 WRITE: lasts exactly one cycle. It drives o_sram_we=1, o_sram_addr=counter, and o_sram_data=shift register, and updates o_stop_addr to the counter value.
REQ-023 Write latency: o_sram_we SHALL be asserted in the i_clk cycle after the cycle in which the 16th bclk rise is detected.
REQ-024 After WRITE: if the counter equals ADDR_MAX, go to IDLE (memory full); otherwise increment the counter and go to WAIT.
REQ-025 Right-channel bits SHALL never be captured.
REQ-026 i_pause in WAIT or SHIFT: go to PAUSE and discard the partial word; the counter is kept.
REQ-027 PAUSE: on i_start, go to WAIT, so capture re-aligns on the next left frame.
REQ-028 i_stop in WAIT, SHIFT or PAUSE: go to IDLE; o_stop_addr keeps the last written address; no write is issued.
REQ-029 The WRITE cycle SHALL complete even if i_stop or i_pause is asserted in it; the command takes effect in the following cycle.
REQ-030 o_sram_we SHALL be 0 in every state except WRITE.
REQ-031 The address SHALL never wrap past ADDR_MAX.

Reset
REQ-032 Reset SHALL force state S_IDLE and set o_sram_we=0, o_sram_addr=0, o_sram_data=0, o_stop_addr=0, o_state=0, and clear all counters and edge registers.
REQ-033 Reset asserted mid-SHIFT or mid-WRITE SHALL abort with no write strobe in the cycle after reset is released.

Structure
REQ-034 Package aud_pkg SHALL hold the state enum (3-bit), SAMPLE_W=16, ADDR_W=20, and the ADDR_MAX default.
REQ-035 One sub-module, aud_edge_det, SHALL provide registered edge detection for i_bclk and i_adclrck; it is instantiated once per signal.

Verification
REQ-036 Start, then three left frames with samples 16'hA5A5, 16'h1234, 16'h8000: three o_sram_we pulses at addresses 0, 1, 2 with those data values; o_stop_addr=2.
REQ-037 Right-channel value 16'hFFFF interleaved with left 16'h0001: only 16'h0001 is written; no write occurs during the right half.
REQ-038 Pause asserted after 8 bits of a frame, then start: the partial word is discarded; the next full left frame 16'h5555 is written at the next address with no gap.
REQ-039 ADDR_MAX=3, with five frames supplied: writes occur at addresses 0 to 3, then the FSM returns to IDLE; o_stop_addr=3; no fifth write.
REQ-040 i_stop asserted in the same cycle as WRITE: the write completes; the FSM is IDLE on the next cycle; o_stop_addr equals that write address.
REQ-041 Reset pulsed mid-SHIFT: all outputs are 0 and o_state=0; a fresh start writes at address 0.
